// File: rtl/uart_rx_tx_pkg.sv
// Shared definitions for the UART transmitter/receiver: frame constants and FSM state types.
package uart_rx_tx_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxWaitIdle
    } rx_state_e;

    // Counter width able to hold n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit clock counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the half-bit and
// last-clock-of-bit positions.
module uart_baud_cnt
    import uart_rx_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic half_tick,
    output logic full_tick
);

    localparam int unsigned W = cnt_width(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign half_tick = en & (cnt_q == HALF);
    assign full_tick = en & (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_tx.sv
// 8N1 UART with independent transmitter and receiver sharing one system clock.
module uart_rx_tx
    import uart_rx_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_ready,
    output logic       tx_accept,
    output logic       tx,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       start_pulse,
    output logic       framing_error
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned BIT_W = cnt_width(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    // ---------------- transmitter ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic                 tx_q, tx_d;
    logic                 tx_accept_q, tx_accept_d;
    logic                 tx_clr, tx_en, tx_full, tx_half_unused;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (tx_clr),
        .en       (tx_en),
        .half_tick(tx_half_unused),
        .full_tick(tx_full)
    );

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_shift_d  = tx_shift_q;
        tx_bit_d    = tx_bit_q;
        tx_d        = tx_q;
        tx_accept_d = 1'b0;
        tx_clr      = 1'b0;
        tx_en       = (tx_state_q != TxIdle);
        unique case (tx_state_q)
            TxIdle: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    tx_shift_d  = tx_byte;
                    tx_state_d  = TxStart;
                    tx_d        = 1'b0;
                    tx_accept_d = 1'b1;
                    tx_clr      = 1'b1;
                end
            end
            TxStart: begin
                if (tx_full) begin
                    tx_state_d = TxData;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end
            end
            TxData: begin
                // The line is registered, so the next bit is loaded at the end of the current one.
                if (tx_full) begin
                    tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                    if (tx_bit_q == LAST_DATA) begin
                        tx_state_d = TxStop;
                        tx_bit_d   = '0;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                        tx_d     = tx_shift_q[1];
                    end
                end
            end
            TxStop: begin
                tx_d = 1'b1;
                if (tx_full) begin
                    if (tx_bit_q == LAST_STOP) begin
                        tx_state_d = TxIdle;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                tx_state_d = TxIdle;
                tx_d       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state_q  <= TxIdle;
            tx_shift_q  <= '0;
            tx_bit_q    <= '0;
            tx_q        <= 1'b1;
            tx_accept_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_shift_q  <= tx_shift_d;
            tx_bit_q    <= tx_bit_d;
            tx_q        <= tx_d;
            tx_accept_q <= tx_accept_d;
        end
    end

    assign tx_ready  = (tx_state_q == TxIdle);
    assign tx_accept = tx_accept_q;
    assign tx        = tx_q;

    // ---------------- receiver ----------------
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [7:0]           rx_byte_q, rx_byte_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 start_pulse_q, start_pulse_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_clr, rx_en, rx_half, rx_full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (rx_clr),
        .en       (rx_en),
        .half_tick(rx_half),
        .full_tick(rx_full)
    );

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_shift_d    = rx_shift_q;
        rx_bit_d      = rx_bit_q;
        rx_byte_d     = rx_byte_q;
        rx_valid_d    = 1'b0;
        start_pulse_d = 1'b0;
        ferr_d        = 1'b0;
        rx_clr        = 1'b0;
        rx_en         = (rx_state_q == RxStart) || (rx_state_q == RxData) ||
                        (rx_state_q == RxStop);
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    start_pulse_d = 1'b1;
                    rx_state_d    = RxStart;
                    rx_clr        = 1'b1;
                end
            end
            RxStart: begin
                // Restart the counter at the start-bit centre so full ticks land on bit centres.
                if (rx_half) begin
                    if (rx_sync_q) begin
                        rx_state_d = RxIdle;
                    end else begin
                        rx_state_d = RxData;
                        rx_bit_d   = '0;
                        rx_clr     = 1'b1;
                    end
                end
            end
            RxData: begin
                if (rx_full) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST_DATA) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_W'(1);
                    end
                end
            end
            RxStop: begin
                if (rx_full) begin
                    if (rx_sync_q) begin
                        rx_byte_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        rx_state_d = RxIdle;
                    end else begin
                        ferr_d     = 1'b1;
                        rx_state_d = RxWaitIdle;
                    end
                end
            end
            RxWaitIdle: begin
                if (rx_sync_q) begin
                    rx_state_d = RxIdle;
                end
            end
            default: begin
                rx_state_d = RxIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state_q    <= RxIdle;
            rx_shift_q    <= '0;
            rx_bit_q      <= '0;
            rx_byte_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            start_pulse_q <= 1'b0;
            ferr_q        <= 1'b0;
        end else begin
            rx_state_q    <= rx_state_d;
            rx_shift_q    <= rx_shift_d;
            rx_bit_q      <= rx_bit_d;
            rx_byte_q     <= rx_byte_d;
            rx_valid_q    <= rx_valid_d;
            start_pulse_q <= start_pulse_d;
            ferr_q        <= ferr_d;
        end
    end

    assign rx_valid      = rx_valid_q;
    assign rx_byte       = rx_byte_q;
    assign start_pulse   = start_pulse_q;
    assign framing_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_tx.sv
// Self-checking bench for uart_rx_tx: table of TX/RX frame vectors plus loopback, glitch and
// mid-frame reset sequences, checked against a bit-time reference model.
module tb_uart_rx_tx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115200;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * CPB;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_ready, tx_accept, tx;
    logic       rx_valid, start_pulse, framing_error;
    logic [7:0] rx_byte;
    logic       rx_drv = 1'b1;
    logic       loop = 1'b0;
    logic       rx_line;

    assign rx_line = loop ? tx : rx_drv;

    uart_rx_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .tx_start     (tx_start),
        .tx_byte      (tx_byte),
        .tx_ready     (tx_ready),
        .tx_accept    (tx_accept),
        .tx           (tx),
        .rx           (rx_line),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .start_pulse  (start_pulse),
        .framing_error(framing_error)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_acc = 0, n_sp = 0, n_val = 0, n_fe = 0;
    logic [7:0] rxq[$];
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) begin
        if (tx_accept) n_acc <= n_acc + 1;
        if (start_pulse) n_sp <= n_sp + 1;
        if (framing_error) n_fe <= n_fe + 1;
        if (rx_valid) begin
            n_val <= n_val + 1;
            rxq.push_back(rx_byte);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Line level k clocks after the frame begins: start 0, data LSB first, then the stop level.
    function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return stop;
    endfunction

    typedef struct {
        logic [7:0] tx_data;
        logic [7:0] rx_data;
        logic       rx_stop;
        logic       mid_start;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    task automatic wait_ready();
        int i;
        for (i = 0; i < 20000 && !tx_ready; i++) @(negedge clk);
        chk("tx_ready_wait", int'(tx_ready), 1);
    endtask

    task automatic drive_rx_frame(input logic [7:0] d, input logic stop);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            rx_drv = frame_bit(d, stop, k);
        end
        @(negedge clk);
        rx_drv = 1'b1;
    endtask

    // One simultaneous transmit + receive frame.
    task automatic run_vec(input vec_t v);
        int acc0, sp0, val0, fe0, bad, rdy_bad;
        bad = 0;
        rdy_bad = 0;
        wait_ready();
        acc0 = n_acc; sp0 = n_sp; val0 = n_val; fe0 = n_fe;
        @(negedge clk);
        tx_byte  = v.tx_data;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        tx_byte  = ~v.tx_data;
        for (int k = 0; k <= FRAME; k++) begin
            @(negedge clk);
            rx_drv = (k < FRAME) ? frame_bit(v.rx_data, v.rx_stop, k) : 1'b1;
            if (k < FRAME) begin
                if (tx !== frame_bit(v.tx_data, 1'b1, k)) bad++;
                if (tx_ready !== 1'b0) rdy_bad++;
            end
            if (k == 0) chk("tx_accept_pulse", int'(tx_accept), 1);
            if (k == 1) chk("tx_accept_one_cycle", int'(tx_accept), 0);
            if (v.mid_start && k == 2000) begin
                tx_start = 1'b1;
                tx_byte  = 8'hC3;
            end
            if (k == 2001) tx_start = 1'b0;
        end
        chk("tx_idle_after_frame", int'(tx), 1);
        chk("tx_ready_after_frame", int'(tx_ready), 1);
        repeat (10) @(negedge clk);
        if (v.exp_valid) last_good = v.rx_data;
        chk("tx_wave", bad, 0);
        chk("tx_ready_low_in_frame", rdy_bad, 0);
        chk("tx_accept_count", n_acc - acc0, 1);
        chk("rx_start_pulse_count", n_sp - sp0, 1);
        chk("rx_valid_count", n_val - val0, int'(v.exp_valid));
        chk("rx_ferr_count", n_fe - fe0, int'(v.exp_ferr));
        chk("rx_byte", int'(rx_byte), int'(last_good));
    endtask

    task automatic loopback();
        logic [7:0] exp_b[3];
        int idx, cyc, acc0, fe0;
        logic done;
        exp_b[0] = 8'h41; exp_b[1] = 8'h30; exp_b[2] = 8'h7A;
        idx = 0;
        done = 1'b0;
        wait_ready();
        acc0 = n_acc;
        fe0 = n_fe;
        rxq.delete();
        loop = 1'b1;
        @(negedge clk);
        tx_byte  = exp_b[0];
        tx_start = 1'b1;
        for (cyc = 0; cyc < 15000; cyc++) begin
            @(negedge clk);
            if (tx_accept) begin
                idx++;
                if (idx < 3) tx_byte = exp_b[idx];
                else tx_start = 1'b0;
            end
            if (rxq.size() >= 3) begin
                done = 1'b1;
                break;
            end
        end
        tx_start = 1'b0;
        repeat (5) @(negedge clk);
        loop = 1'b0;
        chk("loop_done_300us", int'(done), 1);
        chk("loop_accepts", n_acc - acc0, 3);
        chk("loop_rx_count", rxq.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < rxq.size()) chk("loop_rx_byte", int'(rxq[i]), int'(exp_b[i]));
        end
        chk("loop_ferr", n_fe - fe0, 0);
        last_good = 8'h7A;
        chk("loop_rx_byte_final", int'(rx_byte), int'(last_good));
    endtask

    task automatic glitch_then_frame();
        int sp0, val0, fe0;
        logic [7:0] d;
        sp0 = n_sp; val0 = n_val; fe0 = n_fe;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (100) @(negedge clk);
        rx_drv = 1'b1;
        repeat (400) @(negedge clk);
        chk("glitch_start_pulse", n_sp - sp0, 1);
        chk("glitch_no_valid", n_val - val0, 0);
        chk("glitch_no_ferr", n_fe - fe0, 0);
        chk("glitch_rx_byte", int'(rx_byte), int'(last_good));
        d = 8'($urandom);
        drive_rx_frame(d, 1'b1);
        repeat (10) @(negedge clk);
        last_good = d;
        chk("post_glitch_valid", n_val - val0, 1);
        chk("post_glitch_byte", int'(rx_byte), int'(last_good));
    endtask

    task automatic reset_mid_frame();
        int acc0, low_cnt;
        low_cnt = 0;
        wait_ready();
        @(negedge clk);
        tx_byte  = 8'h00;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        repeat (1000) @(negedge clk);
        chk("pre_reset_tx_low", int'(tx), 0);
        rstn = 1'b0;
        #1;
        last_good = 8'h00;
        chk("rst_mid_tx", int'(tx), 1);
        chk("rst_mid_tx_ready", int'(tx_ready), 1);
        chk("rst_mid_tx_accept", int'(tx_accept), 0);
        chk("rst_mid_rx_byte", int'(rx_byte), 0);
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        acc0 = n_acc;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) low_cnt++;
        end
        chk("post_reset_tx_idle", low_cnt, 0);
        chk("post_reset_tx_ready", int'(tx_ready), 1);
        chk("post_reset_no_accept", n_acc - acc0, 0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'h55, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 3; i < 6; i++) begin
            vecs[i].tx_data   = 8'($urandom);
            vecs[i].rx_data   = 8'($urandom);
            vecs[i].rx_stop   = ($urandom_range(0, 3) != 0);
            vecs[i].mid_start = 1'($urandom_range(0, 1));
            vecs[i].exp_valid = vecs[i].rx_stop;
            vecs[i].exp_ferr  = ~vecs[i].rx_stop;
        end

        repeat (3) @(negedge clk);
        chk("reset_tx", int'(tx), 1);
        chk("reset_tx_ready", int'(tx_ready), 1);
        chk("reset_tx_accept", int'(tx_accept), 0);
        chk("reset_rx_valid", int'(rx_valid), 0);
        chk("reset_rx_byte", int'(rx_byte), 0);
        chk("reset_start_pulse", int'(start_pulse), 0);
        chk("reset_framing_error", int'(framing_error), 0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        loopback();
        glitch_then_frame();
        reset_mid_frame();
        run_vec('{8'($urandom), 8'h96, 1'b1, 1'b0, 1'b1, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_tx.md
UART_RX_TX -- requirements
Module: uart_rx_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer truncated (434 at defaults).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 tx_start  input  1  request to transmit tx_byte; honoured only while tx_ready=1.
REQ-006 tx_byte  input  8  byte to transmit; sampled on the accepting edge.
REQ-007 tx_ready  output  1  transmitter idle, able to accept.
REQ-008 tx_accept  output  1  one-cycle pulse: byte accepted.
REQ-009 tx  output  1  serial line out, idle high.
REQ-010 rx  input  1  serial line in, asynchronous to clk, idle high.
REQ-011 rx_valid  output  1  one-cycle pulse: rx_byte holds a new good byte.
REQ-012 rx_byte  output  8  last correctly received byte.
REQ-013 start_pulse  output  1  one-cycle pulse on detected start-bit falling edge.
REQ-014 framing_error  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-015 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each CLKS_PER_BIT clocks.
REQ-016 TX states SHALL be IDLE, START, DATA, STOP; tx_ready=1 only in IDLE.
REQ-017 On a rising edge with tx_start=1 in IDLE, TX SHALL latch tx_byte, pulse tx_accept for exactly one cycle, drop tx_ready and drive tx=0 from that edge.
REQ-018 tx_start while not IDLE SHALL be ignored (no accept pulse, frame unaffected); tx_byte changes after acceptance SHALL not affect the frame.
REQ-019 After the full stop bit (10*CLKS_PER_BIT clocks after acceptance) TX SHALL return to IDLE with tx_ready=1; a tx_start held then SHALL start the next frame on that edge (back-to-back frames, no idle gap).
REQ-020 rx SHALL pass a 2-flop synchronizer before any use; all RX decisions use the synchronized value.
REQ-021 RX states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-022 In IDLE a synchronized 1->0 transition SHALL pulse start_pulse one cycle and enter START.
REQ-023 START SHALL resample at CLKS_PER_BIT/2; if high, treat as glitch and return to IDLE with no other output.
REQ-024 DATA SHALL sample each bit at its centre (every CLKS_PER_BIT after the start-bit centre), shifting LSB first.
REQ-025 At stop-bit centre: if 1, rx_byte SHALL update and rx_valid pulse one cycle in the same cycle, then IDLE; if 0, framing_error SHALL pulse one cycle, rx_byte unchanged, no rx_valid, then WAIT_IDLE.
REQ-026 WAIT_IDLE SHALL return to IDLE only once synchronized rx is 1.
REQ-027 TX and RX SHALL operate fully independently (simultaneous transmit and receive allowed).
REQ-028 Bit counters SHALL be wide enough for CLKS_PER_BIT-1 and count 0..CLKS_PER_BIT-1, wrapping to 0.

Reset
REQ-029 While rstn=0: tx=1, tx_ready=1, tx_accept=0, rx_valid=0, rx_byte=8'h00, start_pulse=0, framing_error=0, both FSMs IDLE, counters 0, synchronizer flops 1.
REQ-030 Reset mid-frame SHALL abort immediately; after release TX idles high and RX waits for a fresh falling edge.

Structure
REQ-031 Shared package SHALL hold the TX/RX state enums and the frame constants (DATA_BITS=8, stop-bit count 1).
REQ-032 Top SHALL instantiate one natural sub-module, uart_baud_cnt (per-bit clock counter with half-bit and full-bit strobes), once for TX and once for RX.

Verification
REQ-033 Loopback tx->rx, send 0x41, 0x30, 0x7A back-to-back -> three tx_accept pulses, rx_valid with rx_byte 0x41, 0x30, 0x7A in order, framing_error never, all done within 300 us.
REQ-034 Send 0x55 -> tx low for exactly 434 clocks after accept, then bits 1,0,1,0,1,0,1,0 each 434 clocks, then high; tx_ready returns after 4340 clocks.
REQ-035 Drive rx low for 10 bit times then high -> start_pulse once, framing_error pulse, no rx_valid, rx_byte unchanged.
REQ-036 rx low pulse of 100 clocks -> start_pulse once, no rx_valid, no framing_error, RX back in IDLE.
REQ-037 tx_start pulsed mid-frame -> no tx_accept, frame intact; rstn asserted mid-frame -> tx=1, tx_ready=1 immediately.
